// File: rtl/hazard_pkg.sv
// Shared slot type and configuration helpers for the hazard scoreboard.
// Slot fields are sized for the widest supported build; narrower builds keep the upper bits at zero.
package hazard_pkg;
  localparam int MAX_AW = 8;
  localparam int MAX_CW = 4;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] dst;
    logic [MAX_CW-1:0] cnt;
  } slot_t;

  function automatic int cnt_width(input int load_lat);
    return $clog2(load_lat + 2);
  endfunction

  function automatic bit cfg_ok(input int aw, input int depth, input int load_lat, input int br_stage);
    return (aw >= 1) && (aw <= MAX_AW) && (depth >= 2) && (br_stage >= 1) &&
           (br_stage <= depth - 1) && (load_lat >= 0) && (cnt_width(load_lat) <= MAX_CW);
  endfunction
endpackage

// File: rtl/scoreboard_match.sv
// Youngest-first priority matcher: reports the lowest-index valid slot in LO..DEPTH-1 whose
// destination equals src_i. Register 0 never matches.
module scoreboard_match
  import hazard_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int LO    = 0,
  parameter int IW    = $clog2(DEPTH)
) (
  input  slot_t [DEPTH-1:0] slots_i,
  input  logic  [AW-1:0]    src_i,
  output logic              hit_o,
  output logic  [IW-1:0]    idx_o,
  output logic  [MAX_CW-1:0] cnt_o
);
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    cnt_o = '0;
    // Scan oldest to youngest so the youngest match overwrites.
    for (int k = DEPTH - 1; k >= LO; k--) begin
      if (slots_i[k].valid && (slots_i[k].dst == MAX_AW'(src_i)) && (src_i != '0)) begin
        hit_o = 1'b1;
        idx_o = IW'(k);
        cnt_o = slots_i[k].cnt;
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writes; derives stall, bubble, flush and
// EX operand forward selects for an in-order pipeline.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 1,
  parameter int RF_WT    = 1,
  parameter int FW       = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rt,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic [AW-1:0] id_dst,
  input  logic          flush_i,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          if_id_flush,
  output logic          ctrl_bubble,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic [15:0]   stall_count
);
  if (!cfg_ok(AW, DEPTH, LOAD_LAT, BR_STAGE)) begin : g_bad_cfg
    $error("hazard_scoreboard: unsupported AW/DEPTH/LOAD_LAT/BR_STAGE combination");
  end

  slot_t [DEPTH-1:0] slot_q, slot_d;
  logic [AW-1:0]     ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic              ex_use_rt_q, ex_use_rt_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic              id_a_hit, id_b_hit, ex_a_hit, ex_b_hit;
  logic [FW-1:0]     id_a_idx, id_b_idx, ex_a_idx, ex_b_idx;
  logic [MAX_CW-1:0] id_a_cnt, id_b_cnt, ex_a_cnt, ex_b_cnt;
  logic              haz_a, haz_b, stall, issue;

  scoreboard_match #(.AW(AW), .DEPTH(DEPTH), .LO(0), .IW(FW)) u_id_a (
    .slots_i(slot_q), .src_i(id_rs), .hit_o(id_a_hit), .idx_o(id_a_idx), .cnt_o(id_a_cnt));
  scoreboard_match #(.AW(AW), .DEPTH(DEPTH), .LO(0), .IW(FW)) u_id_b (
    .slots_i(slot_q), .src_i(id_rt), .hit_o(id_b_hit), .idx_o(id_b_idx), .cnt_o(id_b_cnt));
  // Slot 0 holds the EX instruction itself, so EX forwarding searches from slot 1.
  scoreboard_match #(.AW(AW), .DEPTH(DEPTH), .LO(1), .IW(FW)) u_ex_a (
    .slots_i(slot_q), .src_i(ex_rs_q), .hit_o(ex_a_hit), .idx_o(ex_a_idx), .cnt_o(ex_a_cnt));
  scoreboard_match #(.AW(AW), .DEPTH(DEPTH), .LO(1), .IW(FW)) u_ex_b (
    .slots_i(slot_q), .src_i(ex_rt_q), .hit_o(ex_b_hit), .idx_o(ex_b_idx), .cnt_o(ex_b_cnt));

  function automatic logic id_hazard(input logic hit, input logic [FW-1:0] idx,
                                     input logic [MAX_CW-1:0] cnt);
    return hit && ((cnt > MAX_CW'(1)) || ((RF_WT == 0) && (idx == FW'(DEPTH - 1))));
  endfunction

  assign haz_a = id_hazard(id_a_hit, id_a_idx, id_a_cnt);
  assign haz_b = id_use_rt && id_hazard(id_b_hit, id_b_idx, id_b_cnt);
  assign stall = (haz_a || haz_b) && !flush_i;
  assign issue = id_regwrite && (id_dst != '0) && !stall && !flush_i;

  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign ctrl_bubble = stall || flush_i;
  assign if_id_flush = flush_i;
  assign fwd_a       = (ex_a_hit && (ex_a_cnt == '0)) ? ex_a_idx : FW'(FWD_RF);
  assign fwd_b       = (ex_use_rt_q && ex_b_hit && (ex_b_cnt == '0)) ? ex_b_idx : FW'(FWD_RF);
  assign stall_count = stall_count_q;

  always_comb begin
    slot_d = '0;
    if (issue) begin
      slot_d[0].valid = 1'b1;
      slot_d[0].dst   = MAX_AW'(id_dst);
      slot_d[0].cnt   = id_memread ? MAX_CW'(LOAD_LAT + 1) : MAX_CW'(1);
    end
    for (int k = 1; k < DEPTH; k++) begin
      slot_d[k]     = slot_q[k-1];
      slot_d[k].cnt = (slot_q[k-1].cnt == '0) ? '0 : slot_q[k-1].cnt - MAX_CW'(1);
      // Entries younger than the resolving branch are wrong-path work.
      if (flush_i && (k - 1 < BR_STAGE)) slot_d[k].valid = 1'b0;
    end
  end

  // Any bubble entering EX (stall or flush) must not request forwarding.
  assign ex_rs_d       = ctrl_bubble ? '0 : id_rs;
  assign ex_rt_d       = ctrl_bubble ? '0 : id_rt;
  assign ex_use_rt_d   = ctrl_bubble ? 1'b0 : id_use_rt;
  assign stall_count_d = (stall && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                                 : stall_count_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      slot_q        <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_use_rt_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      slot_q        <= slot_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_use_rt_q   <= ex_use_rt_d;
      stall_count_q <= stall_count_d;
    end
  end

  a_ex_a_ready: assert property (@(posedge CLK) disable iff (!RST)
    !(ex_a_hit && (ex_a_cnt != '0)));
  a_ex_b_ready: assert property (@(posedge CLK) disable iff (!RST)
    !(ex_use_rt_q && ex_b_hit && (ex_b_cnt != '0)));
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Three scoreboard builds share one ID stream; each is checked against an issue-history model
// plus directed expectations for the characteristic hazard scenarios.
module tb_hazard_scoreboard;
  localparam int NC = 3;

  logic clk, rst_n;
  logic [4:0] id_rs, id_rt, id_dst;
  logic id_use_rt, id_regwrite, id_memread, flush_i;

  logic [NC-1:0] pcw, ifw, ifl, bub;
  logic [1:0]  fwa  [NC];
  logic [1:0]  fwb  [NC];
  logic [15:0] scnt [NC];

  hazard_scoreboard #(.AW(5), .DEPTH(3), .LOAD_LAT(1), .BR_STAGE(1), .RF_WT(1)) dut0 (
    .CLK(clk), .RST(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dst(id_dst), .flush_i(flush_i),
    .pc_write(pcw[0]), .if_id_write(ifw[0]), .if_id_flush(ifl[0]), .ctrl_bubble(bub[0]),
    .fwd_a(fwa[0]), .fwd_b(fwb[0]), .stall_count(scnt[0]));
  hazard_scoreboard #(.AW(5), .DEPTH(4), .LOAD_LAT(2), .BR_STAGE(2), .RF_WT(1)) dut1 (
    .CLK(clk), .RST(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dst(id_dst), .flush_i(flush_i),
    .pc_write(pcw[1]), .if_id_write(ifw[1]), .if_id_flush(ifl[1]), .ctrl_bubble(bub[1]),
    .fwd_a(fwa[1]), .fwd_b(fwb[1]), .stall_count(scnt[1]));
  hazard_scoreboard #(.AW(5), .DEPTH(3), .LOAD_LAT(1), .BR_STAGE(1), .RF_WT(0)) dut2 (
    .CLK(clk), .RST(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dst(id_dst), .flush_i(flush_i),
    .pc_write(pcw[2]), .if_id_write(ifw[2]), .if_id_flush(ifl[2]), .ctrl_bubble(bub[2]),
    .fwd_a(fwa[2]), .fwd_b(fwb[2]), .stall_count(scnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depth_of(input int c); return (c == 1) ? 4 : 3; endfunction
  function automatic int ll_of(input int c);    return (c == 1) ? 2 : 1; endfunction
  function automatic int br_of(input int c);    return (c == 1) ? 2 : 1; endfunction
  function automatic int rfwt_of(input int c);  return (c == 2) ? 0 : 1; endfunction

  // Model: each issued write remembers its issue cycle; its pipeline stage is the age since issue.
  typedef struct { int cfg; int issue; int dst; bit ld; } ent_t;
  ent_t infl[$];
  int   cyc;
  int   m_ex_rs [NC];
  int   m_ex_rt [NC];
  bit   m_ex_use[NC];
  int   m_scnt  [NC];
  bit   m_stall [NC];
  int   checks, failures;

  function automatic int ready_stage(input int c, input bit ld);
    return ld ? ll_of(c) + 1 : 1;
  endfunction

  function automatic bit src_hazard(input int c, input int s);
    int best, st;
    bit ld;
    best = -1;
    ld   = 1'b0;
    if (s == 0) return 1'b0;
    foreach (infl[i])
      if (infl[i].cfg == c && infl[i].dst == s && infl[i].issue > best) begin
        best = infl[i].issue;
        ld   = infl[i].ld;
      end
    if (best < 0) return 1'b0;
    st = cyc - best - 1;
    // Consumer reaches EX next cycle, when the producer will sit one stage further on.
    return (st + 1 < ready_stage(c, ld)) || (rfwt_of(c) == 0 && st == depth_of(c) - 1);
  endfunction

  function automatic int exp_fwd(input int c, input int s);
    int best, st;
    best = -1;
    if (s == 0) return 0;
    foreach (infl[i]) begin
      st = cyc - infl[i].issue - 1;
      if (infl[i].cfg == c && infl[i].dst == s && st >= 1 && st >= ready_stage(c, infl[i].ld) &&
          (best < 0 || st < best))
        best = st;
    end
    return (best < 0) ? 0 : best;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit hz, st;
    int fa, fb;
    for (int c = 0; c < NC; c++) begin
      hz = src_hazard(c, int'(id_rs)) || (id_use_rt && src_hazard(c, int'(id_rt)));
      st = hz && !flush_i;
      m_stall[c] = st;
      fa = exp_fwd(c, m_ex_rs[c]);
      fb = m_ex_use[c] ? exp_fwd(c, m_ex_rt[c]) : 0;
      chk($sformatf("c%0d_pc_write", c),    32'(pcw[c]), 32'(!st));
      chk($sformatf("c%0d_if_id_write", c), 32'(ifw[c]), 32'(!st));
      chk($sformatf("c%0d_if_id_flush", c), 32'(ifl[c]), 32'(flush_i));
      chk($sformatf("c%0d_ctrl_bubble", c), 32'(bub[c]), 32'(st || flush_i));
      chk($sformatf("c%0d_fwd_a", c),       32'(fwa[c]), fa);
      chk($sformatf("c%0d_fwd_b", c),       32'(fwb[c]), fb);
      chk($sformatf("c%0d_stall_count", c), 32'(scnt[c]), m_scnt[c]);
    end
  endtask

  task automatic drive(input int rs, input int rt, input bit use_rt, input bit rw,
                       input bit mr, input int dst, input bit fl);
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rt = use_rt;
    id_regwrite = rw; id_memread = mr; id_dst = 5'(dst); flush_i = fl;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      if (flush_i)
        for (int i = infl.size() - 1; i >= 0; i--)
          if (infl[i].cfg == c && (cyc - infl[i].issue - 1) < br_of(c)) infl.delete(i);
      if (id_regwrite && id_dst != 0 && !m_stall[c] && !flush_i)
        infl.push_back('{cfg: c, issue: cyc, dst: int'(id_dst), ld: id_memread});
      if (m_stall[c] || flush_i) begin
        m_ex_rs[c] = 0; m_ex_rt[c] = 0; m_ex_use[c] = 1'b0;
      end else begin
        m_ex_rs[c] = int'(id_rs); m_ex_rt[c] = int'(id_rt); m_ex_use[c] = id_use_rt;
      end
      if (m_stall[c] && m_scnt[c] < 65535) m_scnt[c]++;
    end
    $display("txn cyc=%0d rs=%0d rt=%0d use_rt=%0d rw=%0d ld=%0d dst=%0d flush=%0d stall=%0d%0d%0d",
             cyc, id_rs, id_rt, id_use_rt, id_regwrite, id_memread, id_dst, flush_i,
             m_stall[0], m_stall[1], m_stall[2]);
    cyc++;
    for (int i = infl.size() - 1; i >= 0; i--)
      if (cyc - infl[i].issue - 1 > depth_of(infl[i].cfg) - 1) infl.delete(i);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      tick();
    end
  endtask

  task automatic model_reset();
    infl.delete();
    for (int c = 0; c < NC; c++) begin
      m_ex_rs[c] = 0; m_ex_rt[c] = 0; m_ex_use[c] = 1'b0; m_scnt[c] = 0; m_stall[c] = 1'b0;
    end
  endtask

  task automatic reset_values(input string tag);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("%s_c%0d_pc_write", tag, c),    32'(pcw[c]), 1);
      chk($sformatf("%s_c%0d_if_id_write", tag, c), 32'(ifw[c]), 1);
      chk($sformatf("%s_c%0d_ctrl_bubble", tag, c), 32'(bub[c]), 0);
      chk($sformatf("%s_c%0d_if_id_flush", tag, c), 32'(ifl[c]), 0);
      chk($sformatf("%s_c%0d_fwd_a", tag, c),       32'(fwa[c]), 0);
      chk($sformatf("%s_c%0d_fwd_b", tag, c),       32'(fwb[c]), 0);
      chk($sformatf("%s_c%0d_stall_count", tag, c), 32'(scnt[c]), 0);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    model_reset();
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_dst = '0;
    id_use_rt = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0; flush_i = 1'b0;
    #12;
    reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU result forwarded from MEM, then from WB after an independent filler.
    drive(1, 2, 1'b1, 1'b1, 1'b0, 3, 1'b0); tick();
    drive(3, 4, 1'b1, 1'b1, 1'b0, 5, 1'b0); chk("alu_dep_no_stall", 32'(pcw[0]), 1); tick();
    drive(6, 7, 1'b1, 1'b1, 1'b0, 8, 1'b0); chk("alu_fwd_mem", 32'(fwa[0]), 1); tick();
    drive(0, 0, 1'b0, 1'b1, 1'b0, 9, 1'b0); tick();
    drive(0, 0, 1'b0, 1'b1, 1'b0, 10, 1'b0); tick();
    drive(9, 0, 1'b0, 1'b1, 1'b0, 11, 1'b0); tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0); chk("alu_fwd_wb", 32'(fwa[0]), 2); tick();
    nops(4);

    // Load-use: one stall on the default build.
    drive(1, 0, 1'b0, 1'b1, 1'b1, 2, 1'b0); tick();
    drive(2, 11, 1'b1, 1'b1, 1'b0, 12, 1'b0);
    chk("ld_use_pc_write", 32'(pcw[0]), 0); chk("ld_use_bubble", 32'(bub[0]), 1); tick();
    drive(2, 11, 1'b1, 1'b1, 1'b0, 12, 1'b0);
    chk("ld_use_released", 32'(pcw[0]), 1); chk("ld_use_stall_count", 32'(scnt[0]), 1); tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0); chk("ld_use_fwd_wb", 32'(fwa[0]), 2); tick();
    nops(4);

    // Two-cycle load latency on the deeper build.
    drive(1, 0, 1'b0, 1'b1, 1'b1, 5, 1'b0); tick();
    drive(5, 0, 1'b0, 1'b1, 1'b0, 13, 1'b0); chk("ll2_stall1", 32'(pcw[1]), 0); tick();
    drive(5, 0, 1'b0, 1'b1, 1'b0, 13, 1'b0); chk("ll2_stall2", 32'(pcw[1]), 0); tick();
    drive(5, 0, 1'b0, 1'b1, 1'b0, 13, 1'b0); chk("ll2_release", 32'(pcw[1]), 1); tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0); chk("ll2_fwd", 32'(fwa[1]), 3); tick();
    nops(4);

    // Taken branch overrides a load-use hazard and kills the younger load.
    drive(1, 0, 1'b0, 1'b1, 1'b1, 4, 1'b0); tick();
    drive(4, 0, 1'b0, 1'b1, 1'b1, 14, 1'b1);
    chk("flush_no_stall", 32'(pcw[0]), 1); chk("flush_if_id_flush", 32'(ifl[0]), 1);
    chk("flush_bubble", 32'(bub[0]), 1); tick();
    drive(14, 4, 1'b1, 1'b0, 1'b0, 0, 1'b0); chk("flush_not_issued", 32'(pcw[0]), 1); tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0); chk("flush_killed_fwd", 32'(fwb[0]), 0); tick();
    nops(4);

    // Register 0 is never tracked.
    drive(1, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0); tick();
    drive(0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0); chk("r0_no_stall", 32'(pcw[0]), 1); tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("r0_fwd_a", 32'(fwa[0]), 0); chk("r0_fwd_b", 32'(fwb[0]), 0); tick();
    nops(4);

    // Non-write-through register file: one stall against a WB-stage writer.
    drive(1, 0, 1'b0, 1'b1, 1'b0, 7, 1'b0); tick();
    nops(2);
    drive(7, 0, 1'b0, 1'b1, 1'b0, 15, 1'b0);
    chk("wb_match_stall", 32'(pcw[2]), 0); chk("wb_match_wt", 32'(pcw[0]), 1); tick();
    drive(7, 0, 1'b0, 1'b1, 1'b0, 15, 1'b0); chk("wb_match_release", 32'(pcw[2]), 1); tick();
    nops(4);

    // Asynchronous reset in the middle of a stall.
    drive(1, 0, 1'b0, 1'b1, 1'b1, 2, 1'b0); tick();
    drive(2, 0, 1'b0, 1'b1, 1'b0, 3, 1'b0); chk("pre_rst_stall", 32'(pcw[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    reset_values("mid_rst");
    model_reset();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    tick();
    drive(1, 0, 1'b0, 1'b1, 1'b1, 2, 1'b0); chk("post_rst_issue", 32'(pcw[0]), 1); tick();
    drive(2, 0, 1'b0, 1'b1, 1'b0, 3, 1'b0); chk("post_rst_ld_use", 32'(pcw[0]), 0); tick();
    nops(4);

    // Random instruction stream over a small register window.
    for (int i = 0; i < 300; i++) begin
      drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
